mc_path_feeder: RTL and testbench
=================================

# mc_path_feeder

Path buffer and streamer sitting directly upstream of the Monte-Carlo pricing core. It captures one day's worth of N simulated asset prices from the path generator, then streams them to the core once per cycle. It replays the set from index 0 whenever the core requests a resend, and advances through DAY exercise dates, refilling between dates, until the pricing run completes.

## Interface
- N, 256: paths per day (power of two, ≥4)
- W, 12: price / strike width
- DAY, 8: exercise dates per run
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- go  in  1  one-cycle pulse; starts a run; ignored unless in IDLE or DONE
- strike  in  W  strike price; sampled on the accepted go
- in_valid  in  1  generator sample valid
- in_data  in  W  generator sample
- in_ready  out  1  high in FILL only
- core_start  out  1  one-cycle pulse per day, starts the core
- path_out  out  W  streamed sample, registered
- k_out  out  W  latched strike, registered
- resend  in  1  core replay request, level
- core_valid  in  1  core price-done pulse
- day_idx  out  log2(DAY)  current date index
- done  out  1  high in DONE
- err  out  1  sticky protocol error (see Configuration)

## Operation
- States: IDLE, FILL, START, STREAM, DONE.
- IDLE: on go -> FILL; day_idx=0, wr_idx=0, k_out<=strike.
- FILL: in_ready=1. Each in_valid writes mem[wr_idx]; wr_idx++. Write at wr_idx==N-1 -> START.
- START: one cycle. core_start=1, path_out=mem[0], rd_idx<=1 -> STREAM.
- STREAM: each cycle path_out<=mem[rd_idx], rd_idx<=rd_idx+1 mod N. Free-running wrap N-1->0.
- Resend rising edge (resend=1, previous-cycle resend=0) in STREAM: the next cycle has path_out=mem[0], rd_idx<=1. A held-high resend does not re-trigger.
- core_valid in STREAM: if day_idx==DAY-1 -> DONE, else day_idx++, wr_idx=0 -> FILL.
- core_valid takes priority over a simultaneous resend edge. core_valid outside STREAM is ignored.
- DONE: done=1. go -> FILL, as from IDLE.
- mem is N×W and is not reset. Its contents are undefined until written.
- wr_idx and rd_idx are log2(N) bits. Wrap is natural overflow.

## Timing
- Reset values: state IDLE, in_ready 0, core_start 0, path_out 0, k_out 0, day_idx 0, done 0, err 0, resend history 0.
- Reset asserted mid-run aborts at once. All outputs return to reset values. There is no resumption.
- Fill latency: N accepted samples. START follows the cycle after the last write.
- path_out is valid from the START cycle onward. Sample i appears i cycles after core_start, or i cycles after the cycle following a resend edge.
- in_ready is a registered function of state. It drops in the cycle after the N-th write.
- Back-pressure: gaps in in_valid stall the fill only. No samples are lost.

## Configuration
- FEEDER_ERR_CHECK_EN defined: err is set and held until reset on any of these:
  - in_valid while not in FILL
  - resend edge while not in STREAM
  - go while in FILL, START or STREAM
  - Offending inputs are still ignored.
- Not defined: err is tied to 0 and there is no check logic.

## Test plan
- Fill/start: N=256, DAY=8, go with strike=100, then 256 samples valued 0..255 back-to-back -> core_start exactly 1 cycle after the last write. path_out reads 0,1,2,… from the core_start cycle, k_out=100, and wraps 255->0.
- Back-pressure: in_valid toggled 50% -> fill takes 512 cycles, no sample lost, mem[i]=i on readback.
- Resend: resend rises at rd_idx=37 and is held 300 cycles -> next cycle path_out=0, then sequential, no second restart. Deasserting and reasserting resend restarts again from 0.
- Day sequencing: core_valid after each fill -> day_idx steps 0..7. The 8th core_valid -> done=1, in_ready=0. A new go restarts with day_idx=0.
- Simultaneous events: core_valid and a resend edge in the same cycle -> FILL entered, no replay.
- Reset mid-STREAM at day 3: all outputs go to reset values asynchronously. A subsequent go runs a full 8-day sequence. With FEEDER_ERR_CHECK_EN, in_valid in STREAM -> err=1, sticky.

Source files
------------

// File: rtl/mc_path_feeder.sv
// mc_path_feeder: captures one exercise date's worth of N simulated prices from
// the path generator, then streams them to the Monte-Carlo pricing core once per
// cycle. The set replays from index 0 on a resend rising edge. DAY dates are
// processed per run, with a refill between dates.
//
// Optional feature macro: FEEDER_ERR_CHECK_EN enables the sticky protocol error
// flag. When the macro is undefined, err is tied low and no check logic exists.
//
// Ports:
//   clk, rst_n          clock; asynchronous active-low reset
//   go, strike          run start pulse; strike is latched on an accepted go
//   in_valid, in_data   generator samples, accepted only while in FILL
//   in_ready            high while in FILL
//   core_start          one-cycle pulse per date, in the START cycle
//   path_out, k_out     streamed sample and latched strike
//   resend, core_valid  core replay request (level) and date-done pulse
//   day_idx, done, err  current date, run complete, sticky protocol error
module mc_path_feeder #(
  parameter int unsigned N   = 256,
  parameter int unsigned W   = 12,
  parameter int unsigned DAY = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    go,
  input  logic [W-1:0]            strike,
  input  logic                    in_valid,
  input  logic [W-1:0]            in_data,
  output logic                    in_ready,
  output logic                    core_start,
  output logic [W-1:0]            path_out,
  output logic [W-1:0]            k_out,
  input  logic                    resend,
  input  logic                    core_valid,
  output logic [$clog2(DAY)-1:0]  day_idx,
  output logic                    done,
  output logic                    err
);

  localparam int unsigned AW = $clog2(N);
  localparam int unsigned DW = $clog2(DAY);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_START,
    S_STREAM,
    S_DONE
  } state_t;

  state_t         state_q, state_d;
  logic [AW-1:0]  wr_idx_q, wr_idx_d;
  logic [AW-1:0]  rd_idx_q, rd_idx_d;
  logic [W-1:0]   path_d, k_d;
  logic [DW-1:0]  day_d;
  logic           in_ready_d, core_start_d, done_d;
  logic           resend_q;
  logic           res_edge;
  logic           mem_we;
  logic [W-1:0]   mem [N];

  assign res_edge = resend & ~resend_q;

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      wr_idx_q   <= '0;
      rd_idx_q   <= '0;
      path_out   <= '0;
      k_out      <= '0;
      day_idx    <= '0;
      in_ready   <= 1'b0;
      core_start <= 1'b0;
      done       <= 1'b0;
      resend_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_idx_q   <= wr_idx_d;
      rd_idx_q   <= rd_idx_d;
      path_out   <= path_d;
      k_out      <= k_d;
      day_idx    <= day_d;
      in_ready   <= in_ready_d;
      core_start <= core_start_d;
      done       <= done_d;
      resend_q   <= resend;
    end
  end

  // Sample buffer; contents are meaningful only after a fill
  always_ff @(posedge clk) begin
    if (mem_we) mem[wr_idx_q] <= in_data;
  end

  // Next-state and next-output logic
  always_comb begin
    state_d  = state_q;
    wr_idx_d = wr_idx_q;
    rd_idx_d = rd_idx_q;
    path_d   = path_out;
    k_d      = k_out;
    day_d    = day_idx;
    mem_we   = 1'b0;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (go) begin
          state_d  = S_FILL;
          day_d    = '0;
          wr_idx_d = '0;
          k_d      = strike;
        end
      end
      S_FILL: begin
        if (in_valid) begin
          mem_we   = 1'b1;
          wr_idx_d = wr_idx_q + AW'(1);
          if (wr_idx_q == AW'(N - 1)) begin
            // mem[0] was written earlier in this fill, so it is safe to present now
            state_d  = S_START;
            path_d   = mem[0];
            rd_idx_d = AW'(1);
          end
        end
      end
      S_START: begin
        state_d  = S_STREAM;
        path_d   = mem[rd_idx_q];
        rd_idx_d = rd_idx_q + AW'(1);
      end
      S_STREAM: begin
        // Date completion wins over a coincident replay request
        if (core_valid) begin
          if (day_idx == DW'(DAY - 1)) begin
            state_d = S_DONE;
          end else begin
            state_d  = S_FILL;
            day_d    = day_idx + DW'(1);
            wr_idx_d = '0;
          end
        end else if (res_edge) begin
          path_d   = mem[0];
          rd_idx_d = AW'(1);
        end else begin
          path_d   = mem[rd_idx_q];
          rd_idx_d = rd_idx_q + AW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    in_ready_d   = (state_d == S_FILL);
    core_start_d = (state_d == S_START);
    done_d       = (state_d == S_DONE);
  end

`ifdef FEEDER_ERR_CHECK_EN
  logic err_d;

  // Sticky flag for inputs arriving in a state that ignores them
  always_comb begin
    err_d = err;
    if (in_valid && (state_q != S_FILL)) err_d = 1'b1;
    if (res_edge && (state_q != S_STREAM)) err_d = 1'b1;
    if (go && ((state_q == S_FILL) || (state_q == S_START) || (state_q == S_STREAM)))
      err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err <= 1'b0;
    else        err <= err_d;
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_mc_path_feeder.sv
// Self-checking bench for mc_path_feeder: randomized fills and streams checked
// every cycle against a behavioural model, plus literal expectations at key points.
module tb_mc_path_feeder;

  localparam int unsigned N   = 256;
  localparam int unsigned W   = 12;
  localparam int unsigned DAY = 8;

  localparam int P_IDLE = 0, P_FILL = 1, P_START = 2, P_STREAM = 3, P_DONE = 4;

`ifdef FEEDER_ERR_CHECK_EN
  localparam int ERR_EXP = 1;
`else
  localparam int ERR_EXP = 0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         go = 1'b0;
  logic [W-1:0] strike = '0;
  logic         in_valid = 1'b0;
  logic [W-1:0] in_data = '0;
  logic         resend = 1'b0;
  logic         core_valid = 1'b0;
  logic         in_ready, core_start, done, err;
  logic [W-1:0] path_out, k_out;
  logic [2:0]   day_idx;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mc_path_feeder #(.N(N), .W(W), .DAY(DAY)) dut (
    .clk(clk), .rst_n(rst_n), .go(go), .strike(strike),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .core_start(core_start), .path_out(path_out), .k_out(k_out),
    .resend(resend), .core_valid(core_valid), .day_idx(day_idx),
    .done(done), .err(err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: phase, captured samples, and samples-since-restart count
  int ph = P_IDLE;
  int m_day = 0;
  int m_wcnt = 0;
  int m_t = 0;
  int m_k = 0;
  bit m_prev = 1'b0;
  bit m_err = 1'b0;
  int mm [N];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph = P_IDLE; m_day = 0; m_wcnt = 0; m_t = 0; m_k = 0;
      m_prev = 1'b0; m_err = 1'b0;
    end else begin : upd
      bit e;
      e = resend && !m_prev;
      m_prev = resend;
`ifdef FEEDER_ERR_CHECK_EN
      if (in_valid && ph != P_FILL) m_err = 1'b1;
      if (e && ph != P_STREAM) m_err = 1'b1;
      if (go && (ph == P_FILL || ph == P_START || ph == P_STREAM)) m_err = 1'b1;
`endif
      case (ph)
        P_IDLE, P_DONE: if (go) begin
          ph = P_FILL; m_day = 0; m_wcnt = 0; m_k = int'(strike);
        end
        P_FILL: if (in_valid) begin
          mm[m_wcnt] = int'(in_data);
          m_wcnt++;
          if (m_wcnt == N) begin ph = P_START; m_t = 0; end
        end
        P_START: begin ph = P_STREAM; m_t = 1; end
        P_STREAM: begin
          if (core_valid) begin
            if (m_day == DAY - 1) ph = P_DONE;
            else begin m_day++; m_wcnt = 0; ph = P_FILL; end
          end else if (e) m_t = 0;
          else m_t++;
        end
        default: ph = P_IDLE;
      endcase
    end
  end

  // Per-cycle comparison against the model
  initial begin
    forever begin
      @(posedge clk);
      #1;
      chk("in_ready", 32'(in_ready), 32'(ph == P_FILL));
      chk("core_start", 32'(core_start), 32'(ph == P_START));
      chk("done", 32'(done), 32'(ph == P_DONE));
      chk("day_idx", 32'(day_idx), 32'(m_day));
      chk("k_out", 32'(k_out), 32'(m_k));
      chk("err", 32'(err), 32'(m_err));
      if (ph == P_START || ph == P_STREAM)
        chk("path_out", 32'(path_out), 32'(mm[m_t % N]));
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, " in_ready"}, 32'(in_ready), 32'd0);
    chk({tag, " core_start"}, 32'(core_start), 32'd0);
    chk({tag, " path_out"}, 32'(path_out), 32'd0);
    chk({tag, " k_out"}, 32'(k_out), 32'd0);
    chk({tag, " day_idx"}, 32'(day_idx), 32'd0);
    chk({tag, " done"}, 32'(done), 32'd0);
    chk({tag, " err"}, 32'(err), 32'd0);
  endtask

  task automatic do_go(input logic [W-1:0] s);
    go = 1'b1; strike = s;
    tick();
    go = 1'b0;
  endtask

  // mode 0: back-to-back ramp; 1: alternating valid ramp; 2: random gaps, random data
  task automatic fill(input int mode);
    int sent = 0;
    int cyc = 0;
    while (sent < N) begin
      bit v;
      case (mode)
        0: v = 1'b1;
        1: v = cyc[0];
        default: v = ($urandom_range(0, 3) != 0);
      endcase
      in_valid = v;
      in_data  = (mode == 2) ? W'($urandom) : W'(sent);
      tick();
      if (v) sent++;
      cyc++;
    end
    in_valid = 1'b0;
  endtask

  task automatic stream(input int len);
    for (int i = 0; i < len; i++) begin
      if (i > 0 && $urandom_range(0, 15) == 0) resend = ~resend;
      tick();
    end
    resend = 1'b0;
  endtask

  task automatic finish_day();
    core_valid = 1'b1;
    tick();
    core_valid = 1'b0;
  endtask

  task automatic run_day(input int mode, input int len);
    fill(mode);
    stream(len);
    finish_day();
  endtask

  initial begin
    repeat (2) tick();
    chk_reset("reset");
    rst_n = 1'b1;
    tick();

    // Run 1, date 0: ramp fill, wrap, resend behaviour
    do_go(12'd100);
    fill(0);
    chk("start core_start", 32'(core_start), 32'd1);
    chk("start path_out", 32'(path_out), 32'd0);
    chk("start k_out", 32'(k_out), 32'd100);
    repeat (255) tick();
    chk("path before wrap", 32'(path_out), 32'd255);
    tick();
    chk("path after wrap", 32'(path_out), 32'd0);
    chk("core_start pulse", 32'(core_start), 32'd0);
    repeat (36) tick();
    chk("path at 36", 32'(path_out), 32'd36);
    resend = 1'b1;
    tick();
    chk("resend restart", 32'(path_out), 32'd0);
    repeat (299) tick();
    chk("resend held", 32'(path_out), 32'd43);
    resend = 1'b0;
    tick();
    resend = 1'b1;
    tick();
    chk("resend rearm", 32'(path_out), 32'd0);
    resend = 1'b0;
    repeat (10) tick();
    chk("after rearm", 32'(path_out), 32'd10);
    finish_day();
    chk("day1 in_ready", 32'(in_ready), 32'd1);
    chk("day1 day_idx", 32'(day_idx), 32'd1);

    // Date 1: back-pressured fill
    fill(1);
    chk("bp core_start", 32'(core_start), 32'd1);
    chk("bp path_out", 32'(path_out), 32'd0);
    repeat (100) tick();
    chk("bp readback", 32'(path_out), 32'd100);

    // core_valid with a coincident resend edge
    core_valid = 1'b1; resend = 1'b1;
    tick();
    core_valid = 1'b0; resend = 1'b0;
    chk("cv wins in_ready", 32'(in_ready), 32'd1);
    chk("cv wins day_idx", 32'(day_idx), 32'd2);

    for (int d = 2; d < DAY; d++) run_day(2, int'($urandom_range(20, 400)));
    chk("run1 done", 32'(done), 32'd1);
    chk("run1 in_ready", 32'(in_ready), 32'd0);
    chk("run1 day_idx", 32'(day_idx), 32'd7);
    repeat (3) tick();
    chk("done holds", 32'(done), 32'd1);

    // Run 2: restart from DONE, then abort by reset at date 3
    do_go(W'($urandom));
    chk("run2 day_idx", 32'(day_idx), 32'd0);
    chk("run2 in_ready", 32'(in_ready), 32'd1);
    chk("run2 done", 32'(done), 32'd0);
    for (int d = 0; d < 3; d++) run_day(2, int'($urandom_range(20, 200)));
    chk("run2 day3", 32'(day_idx), 32'd3);
    fill(2);
    stream(50);
    #2 rst_n = 1'b0;
    #1 chk_reset("async");
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Run 3: full sequence, with a stray in_valid during streaming
    do_go(12'd777);
    fill(2);
    stream(30);
    chk("err clean", 32'(err), 32'd0);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("err set", 32'(err), 32'(ERR_EXP));
    stream(30);
    chk("err sticky", 32'(err), 32'(ERR_EXP));
    finish_day();
    for (int d = 1; d < DAY; d++) run_day(2, int'($urandom_range(20, 300)));
    chk("run3 done", 32'(done), 32'd1);
    chk("run3 day_idx", 32'(day_idx), 32'd7);
    chk("run3 k_out", 32'(k_out), 32'd777);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
